// File: rtl/cc_poly_fmt_pkg.sv
// rtl/cc_poly_fmt_pkg.sv - shared widths, FSM encoding and chunk/mask helpers for cc_poly_fmt
package cc_poly_fmt_pkg;

    localparam int BLK_W  = 128;
    localparam int WORD_W = 512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AAD,
        S_WAIT,
        S_CT,
        S_LEN,
        S_DONE
    } state_t;

    function automatic logic [31:0] min64(input logic [31:0] n);
        return (n > 32'd64) ? 32'd64 : n;
    endfunction

    // n is already clamped to 0..64, so the chunk count fits in 3 bits
    function automatic logic [2:0] chunk_cnt(input logic [31:0] n);
        return 3'((n + 32'd15) >> 4);
    endfunction

    function automatic logic [WORD_W-1:0] byte_mask(input logic [31:0] n);
        logic [WORD_W-1:0] ones;
        ones = '1;
        if (n >= 32'd64) return ones;
        return ones >> ((32'd64 - n) * 32'd8);
    endfunction

endpackage

// File: rtl/cc_poly_fmt_if.sv
// rtl/cc_poly_fmt_if.sv - control, ciphertext and block handshake bundle for cc_poly_fmt
interface cc_poly_fmt_if;
    import cc_poly_fmt_pkg::*;

    logic              i_start;
    logic [WORD_W-1:0] i_aad;
    logic [31:0]       i_len_aad;
    logic [31:0]       i_len_ct;
    logic              i_ct_vld;
    logic [WORD_W-1:0] i_ct;
    logic              o_ct_rdy;
    logic [BLK_W-1:0]  o_blk;
    logic              o_blk_vld;
    logic              i_blk_rdy;
    logic              o_blk_last;
    logic              o_err;
    logic              o_done;

    modport master (
        output i_start, i_aad, i_len_aad, i_len_ct, i_ct_vld, i_ct, i_blk_rdy,
        input  o_ct_rdy, o_blk, o_blk_vld, o_blk_last, o_err, o_done
    );

    modport slave (
        input  i_start, i_aad, i_len_aad, i_len_ct, i_ct_vld, i_ct, i_blk_rdy,
        output o_ct_rdy, o_blk, o_blk_vld, o_blk_last, o_err, o_done
    );

endinterface

// File: rtl/cc_poly_fmt_word_buf.sv
// rtl/cc_poly_fmt_word_buf.sv - single-entry ciphertext word buffer with overflow detect
module cc_word_buf
    import cc_poly_fmt_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              fill,
    input  logic              free,
    input  logic [WORD_W-1:0] data,
    output logic              full,
    output logic [WORD_W-1:0] q,
    output logic              ovf
);

    // A word arriving in the same cycle the entry drains takes the slot
    assign ovf = fill && full && !free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= 1'b0;
            q    <= '0;
        end else if (clr) begin
            full <= 1'b0;
            q    <= '0;
        end else if (fill && (!full || free)) begin
            full <= 1'b1;
            q    <= data;
        end else if (free) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cc_poly_fmt.sv
// rtl/cc_poly_fmt.sv - builds the AEAD Poly1305 input stream from AAD, ciphertext words and lengths
module cc_poly_fmt
    import cc_poly_fmt_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rstn,
    cc_poly_fmt_if.slave bus
);

    state_t            state;
    logic [1:0]        idx;
    logic [2:0]        cnt;
    logic [31:0]       len_aad;
    logic [31:0]       len_ct;
    logic [31:0]       ct_rem;
    logic [WORD_W-1:0] aad_q;
    logic              err;

    logic              buf_full;
    logic              buf_ovf;
    logic [WORD_W-1:0] buf_q;

    logic              fire;
    logic              last_chunk;
    logic              start_ok;
    logic              ct_free;
    logic              ct_fill;
    logic [31:0]       aad_sat;
    logic [31:0]       ct_take;
    logic [31:0]       rem_next;
    logic [1:0]        sel_idx;
    logic [WORD_W-1:0] ct_word;
    logic [BLK_W-1:0]  aad_chunk;
    logic [BLK_W-1:0]  ct_chunk;

    assign fire       = bus.o_blk_vld && bus.i_blk_rdy;
    assign last_chunk = ({1'b0, idx} == cnt - 3'd1);
    assign start_ok   = (state == S_IDLE) && bus.i_start;
    assign aad_sat    = min64(bus.i_len_aad);
    assign ct_take    = min64(ct_rem);
    assign rem_next   = ct_rem - ct_take;
    assign ct_free    = (state == S_CT) && fire && last_chunk;
    // Words past the end of the message are ignored, including one racing the final free
    assign ct_fill    = bus.i_ct_vld && (state != S_IDLE) && (ct_rem != 32'd0)
                        && !(ct_free && (rem_next == 32'd0));

    // First load of a word presents chunk idx; each acceptance advances to idx+1
    assign sel_idx    = bus.o_blk_vld ? idx + 2'd1 : idx;
    assign ct_word    = buf_q & byte_mask(ct_take);
    assign aad_chunk  = aad_q[{sel_idx, 7'd0} +: BLK_W];
    assign ct_chunk   = ct_word[{sel_idx, 7'd0} +: BLK_W];

    assign bus.o_ct_rdy = !buf_full;
    assign bus.o_err    = err;

    cc_word_buf u_word_buf (
        .clk  (i_clk),
        .rstn (i_rstn),
        .clr  (start_ok),
        .fill (ct_fill),
        .free (ct_free),
        .data (bus.i_ct),
        .full (buf_full),
        .q    (buf_q),
        .ovf  (buf_ovf)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= S_IDLE;
            idx            <= '0;
            cnt            <= '0;
            len_aad        <= '0;
            len_ct         <= '0;
            ct_rem         <= '0;
            aad_q          <= '0;
            err            <= 1'b0;
            bus.o_blk      <= '0;
            bus.o_blk_vld  <= 1'b0;
            bus.o_blk_last <= 1'b0;
            bus.o_done     <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            if (buf_ovf) err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        len_aad <= aad_sat;
                        len_ct  <= bus.i_len_ct;
                        ct_rem  <= bus.i_len_ct;
                        aad_q   <= bus.i_aad & byte_mask(aad_sat);
                        err     <= 1'b0;
                        idx     <= '0;
                        cnt     <= chunk_cnt(aad_sat);
                        if (aad_sat != 32'd0)           state <= S_AAD;
                        else if (bus.i_len_ct != 32'd0) state <= S_WAIT;
                        else                            state <= S_LEN;
                    end
                end
                S_AAD: begin
                    if (!bus.o_blk_vld) begin
                        bus.o_blk     <= aad_chunk;
                        bus.o_blk_vld <= 1'b1;
                    end else if (fire) begin
                        if (last_chunk) begin
                            bus.o_blk_vld <= 1'b0;
                            idx           <= '0;
                            state         <= (ct_rem != 32'd0) ? S_WAIT : S_LEN;
                        end else begin
                            idx       <= idx + 2'd1;
                            bus.o_blk <= aad_chunk;
                        end
                    end
                end
                S_WAIT: begin
                    if (buf_full) begin
                        idx   <= '0;
                        cnt   <= chunk_cnt(ct_take);
                        state <= S_CT;
                    end
                end
                S_CT: begin
                    if (!bus.o_blk_vld) begin
                        bus.o_blk     <= ct_chunk;
                        bus.o_blk_vld <= 1'b1;
                    end else if (fire) begin
                        if (last_chunk) begin
                            bus.o_blk_vld <= 1'b0;
                            idx           <= '0;
                            ct_rem        <= rem_next;
                            if (rem_next == 32'd0) begin
                                state <= S_LEN;
                            end else if (ct_fill) begin
                                cnt   <= chunk_cnt(min64(rem_next));
                                state <= S_CT;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            idx       <= idx + 2'd1;
                            bus.o_blk <= ct_chunk;
                        end
                    end
                end
                S_LEN: begin
                    if (!bus.o_blk_vld) begin
                        bus.o_blk      <= {32'd0, len_ct, 32'd0, len_aad};
                        bus.o_blk_vld  <= 1'b1;
                        bus.o_blk_last <= 1'b1;
                    end else if (fire) begin
                        bus.o_blk_vld  <= 1'b0;
                        bus.o_blk_last <= 1'b0;
                        bus.o_done     <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_poly_fmt.sv
// tb/tb_cc_poly_fmt.sv - scoreboard bench for cc_poly_fmt
module tb_cc_poly_fmt;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cc_poly_fmt_if bus ();

    cc_poly_fmt dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [128:0] got_q[$];
    logic [128:0] exp_q[$];
    logic [511:0] ct_words[$];
    logic [511:0] exp_words[$];

    int stall_at = -1;
    int stall_left = 0;
    int stable_viol = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic pl = 1'b0;
    logic [127:0] pb = '0;

    // Observed stream plus hold-stability watch while the sink back-pressures
    always @(negedge clk) begin
        if (!rstn) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr && (bus.o_blk !== pb || bus.o_blk_last !== pl || bus.o_blk_vld !== 1'b1))
                stable_viol <= stable_viol + 1;
            pv <= bus.o_blk_vld;
            pr <= bus.i_blk_rdy;
            pb <= bus.o_blk;
            pl <= bus.o_blk_last;
            if (bus.o_blk_vld && bus.i_blk_rdy) got_q.push_back({bus.o_blk_last, bus.o_blk});
        end
    end

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic build_exp(input logic [511:0] aad, input int la, input int lc);
        int las;
        int rem;
        int nb;
        logic [127:0] b;
        logic [511:0] w;
        exp_q.delete();
        las = (la > 64) ? 64 : la;
        for (int k = 0; k * 16 < las; k++) begin
            b = '0;
            for (int j = 0; j < 16; j++)
                if (k * 16 + j < las) b[j*8 +: 8] = aad[(k*16+j)*8 +: 8];
            exp_q.push_back({1'b0, b});
        end
        rem = lc;
        for (int wi = 0; wi < exp_words.size(); wi++) begin
            w = exp_words[wi];
            nb = (rem > 64) ? 64 : rem;
            for (int k = 0; k * 16 < nb; k++) begin
                b = '0;
                for (int j = 0; j < 16; j++)
                    if (k * 16 + j < nb) b[j*8 +: 8] = w[(k*16+j)*8 +: 8];
                exp_q.push_back({1'b0, b});
            end
            rem -= nb;
        end
        exp_q.push_back({1'b1, 32'd0, lc[31:0], 32'd0, las[31:0]});
    endtask

    task automatic start_msg(input logic [511:0] aad, input int la, input int lc);
        got_q.delete();
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_aad = aad;
        bus.i_len_aad = la;
        bus.i_len_ct = lc;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic feed(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            @(posedge clk); #1;
            if (bus.i_ct_vld) begin
                bus.i_ct_vld = 1'b0;
            end else if (ct_words.size() > 0 && bus.o_ct_rdy) begin
                bus.i_ct = ct_words.pop_front();
                bus.i_ct_vld = 1'b1;
            end
            if (stall_left > 0 && got_q.size() == stall_at) begin
                bus.i_blk_rdy = 1'b0;
                stall_left--;
            end else begin
                bus.i_blk_rdy = 1'b1;
            end
            @(negedge clk);
            if (bus.o_done) begin
                ok = 1'b1;
                break;
            end
        end
        bus.i_ct_vld = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_aad = '0;
        bus.i_len_aad = '0;
        bus.i_len_ct = '0;
        bus.i_ct_vld = 1'b0;
        bus.i_ct = '0;
        bus.i_blk_rdy = 1'b1;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.o_blk, bus.o_blk_vld, bus.o_blk_last, bus.o_err, bus.o_done, bus.o_ct_rdy} !== {128'd0, 5'b00001}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got blk=%h vld=%b last=%b err=%b done=%b ct_rdy=%b expected zeros with ct_rdy=1",
                     bus.o_blk, bus.o_blk_vld, bus.o_blk_last, bus.o_err, bus.o_done, bus.o_ct_rdy);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_rfc();
        logic [511:0] aad;
        bit ok;
        aad = rnd512();
        exp_words.delete();
        exp_words.push_back(rnd512());
        exp_words.push_back(rnd512());
        ct_words = exp_words;
        build_exp(aad, 12, 114);
        start_msg(aad, 12, 114);
        feed(400, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rfc_done: got no o_done expected pulse within 400 cycles"); end
        tests_run++;
        if (got_q.size() != 10) begin tests_failed++; $display("FAIL rfc_count: got %0d blocks expected 10", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rfc_blk%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() > 0) begin
            tests_run++;
            if (got_q[got_q.size()-1] !== {1'b1, 64'd114, 64'd12}) begin
                tests_failed++;
                $display("FAIL rfc_len_blk: got %h expected %h", got_q[got_q.size()-1], {1'b1, 64'd114, 64'd12});
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.o_done !== 1'b0) begin tests_failed++; $display("FAIL rfc_done_width: got o_done=%b expected 0", bus.o_done); end
    endtask

    task automatic test_empty();
        bit ok;
        start_msg(rnd512(), 0, 0);
        feed(50, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL empty_done: got no o_done expected pulse within 50 cycles"); end
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++;
            $display("FAIL empty_count: got %0d blocks expected 1", got_q.size());
        end else begin
            tests_run++;
            if (got_q[0] !== {1'b1, 128'd0}) begin
                tests_failed++;
                $display("FAIL empty_blk: got %h expected %h", got_q[0], {1'b1, 128'd0});
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.o_done !== 1'b0) begin tests_failed++; $display("FAIL empty_done_width: got o_done=%b expected 0", bus.o_done); end
    endtask

    task automatic test_aad_sat();
        logic [511:0] aad;
        bit ok;
        aad = rnd512();
        exp_words.delete();
        exp_words.push_back(rnd512());
        ct_words = exp_words;
        build_exp(aad, 80, 64);
        start_msg(aad, 80, 64);
        feed(300, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL sat_done: got no o_done expected pulse within 300 cycles"); end
        tests_run++;
        if (got_q.size() != 9) begin tests_failed++; $display("FAIL sat_count: got %0d blocks expected 9", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL sat_blk%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() > 0) begin
            tests_run++;
            if (got_q[got_q.size()-1] !== {1'b1, 64'd64, 64'd64}) begin
                tests_failed++;
                $display("FAIL sat_len_blk: got %h expected %h", got_q[got_q.size()-1], {1'b1, 64'd64, 64'd64});
            end
        end
    endtask

    task automatic test_stall();
        logic [511:0] aad;
        bit ok;
        int viol0;
        aad = rnd512();
        exp_words.delete();
        for (int i = 0; i < 3; i++) exp_words.push_back(rnd512());
        ct_words = exp_words;
        build_exp(aad, 5, 130);
        viol0 = stable_viol;
        stall_at = 3;
        stall_left = 5;
        start_msg(aad, 5, 130);
        feed(400, ok);
        stall_at = -1;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL stall_done: got no o_done expected pulse within 400 cycles"); end
        tests_run++;
        if (stall_left != 0) begin tests_failed++; $display("FAIL stall_applied: got %0d stall cycles left expected 0", stall_left); end
        tests_run++;
        if (stable_viol != viol0) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d hold violations expected 0", stable_viol - viol0);
        end
        tests_run++;
        if (got_q.size() != 11) begin tests_failed++; $display("FAIL stall_count: got %0d blocks expected 11", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL stall_blk%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() >= 2) begin
            tests_run++;
            if (got_q[got_q.size()-2] !== {1'b0, 112'd0, exp_words[2][15:0]}) begin
                tests_failed++;
                $display("FAIL stall_tail_blk: got %h expected %h", got_q[got_q.size()-2], {1'b0, 112'd0, exp_words[2][15:0]});
            end
        end
    endtask

    task automatic test_overflow();
        logic [511:0] wa;
        logic [511:0] wb;
        bit ok;
        wa = rnd512();
        wb = rnd512();
        exp_words.delete();
        exp_words.push_back(wa);
        exp_words.push_back(rnd512());
        exp_words.push_back(rnd512());
        build_exp('0, 0, 192);
        bus.i_blk_rdy = 1'b0;
        start_msg('0, 0, 192);
        bus.i_ct = wa;
        bus.i_ct_vld = 1'b1;
        @(posedge clk); #1;
        bus.i_ct_vld = 1'b0;
        @(posedge clk); #1;
        bus.i_ct = wb;
        bus.i_ct_vld = 1'b1;
        @(posedge clk); #1;
        bus.i_ct_vld = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.o_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_err_set: got o_err=%b expected 1", bus.o_err); end
        tests_run++;
        if (bus.o_ct_rdy !== 1'b0) begin tests_failed++; $display("FAIL ovf_ct_rdy: got o_ct_rdy=%b expected 0", bus.o_ct_rdy); end
        ct_words.delete();
        ct_words.push_back(exp_words[1]);
        ct_words.push_back(exp_words[2]);
        feed(400, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL ovf_done: got no o_done expected pulse within 400 cycles"); end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL ovf_count: got %0d blocks expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL ovf_blk%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (bus.o_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_err_sticky: got o_err=%b expected 1", bus.o_err); end
        start_msg('0, 0, 0);
        @(negedge clk);
        tests_run++;
        if (bus.o_err !== 1'b0) begin tests_failed++; $display("FAIL ovf_err_clear: got o_err=%b expected 0", bus.o_err); end
        feed(50, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL ovf_clear_done: got no o_done expected pulse within 50 cycles"); end
    endtask

    task automatic test_reset_mid();
        logic [511:0] aad;
        bit ok;
        bit hit;
        hit = 1'b0;
        bus.i_blk_rdy = 1'b1;
        start_msg('0, 0, 128);
        bus.i_ct = rnd512();
        bus.i_ct_vld = 1'b1;
        @(posedge clk); #1;
        bus.i_ct_vld = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (got_q.size() >= 2) begin hit = 1'b1; break; end
        end
        tests_run++;
        if (!hit) begin tests_failed++; $display("FAIL rmid_reach_ct: got %0d blocks expected at least 2 before reset", got_q.size()); end
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({bus.o_blk, bus.o_blk_vld, bus.o_blk_last, bus.o_err, bus.o_done, bus.o_ct_rdy} !== {128'd0, 5'b00001}) begin
            tests_failed++;
            $display("FAIL rmid_outputs: got blk=%h vld=%b last=%b err=%b done=%b ct_rdy=%b expected zeros with ct_rdy=1",
                     bus.o_blk, bus.o_blk_vld, bus.o_blk_last, bus.o_err, bus.o_done, bus.o_ct_rdy);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        aad = rnd512();
        exp_words.delete();
        exp_words.push_back(rnd512());
        ct_words = exp_words;
        build_exp(aad, 20, 50);
        start_msg(aad, 20, 50);
        feed(300, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rmid_done: got no o_done expected pulse within 300 cycles"); end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rmid_count: got %0d blocks expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rmid_blk%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rfc();
        test_empty();
        test_aad_sat();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
